// File: rtl/sqd_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sqd_stream_arbiter
// Purpose  : Shares one byte-wide sequence detector between N_CH packetised
//            byte streams. One requester is granted per packet in round-robin
//            order and its bytes are steered into the detector. The detector
//            is flushed between packets so a pattern can never span two
//            streams. Each detector hit is tagged with the channel whose byte
//            completed it.
// Ports    : clk, reset (async, active-high)
//            arb_en                         - allow new grants
//            req_valid/req_data/req_last    - per-channel byte streams
//            req_ready                      - per-channel ready (one-hot/zero)
//            det_data/det_valid/det_enable  - drive the detector
//            det_hit                        - detector Moore output
//            hit_valid/hit_chan             - qualified, channel-tagged hit
//            busy/grant_chan                - arbiter status
// Option   : SQD_ARB_HITCNT_EN adds cnt_sel, cnt_clr, cnt_val and a
//            saturating 16-bit hit counter per channel.
// Revision : 1.0 - initial release
// ============================================================================
module sqd_stream_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arb_en,
    input  logic [N_CH-1:0]   req_valid,
    input  logic [8*N_CH-1:0] req_data,
    input  logic [N_CH-1:0]   req_last,
    output logic [N_CH-1:0]   req_ready,
    output logic [7:0]        det_data,
    output logic              det_valid,
    output logic              det_enable,
    input  logic              det_hit,
    output logic              hit_valid,
    output logic [CH_W-1:0]   hit_chan,
    output logic              busy,
    output logic [CH_W-1:0]   grant_chan
`ifdef SQD_ARB_HITCNT_EN
    ,
    input  logic [CH_W-1:0]   cnt_sel,
    input  logic              cnt_clr,
    output logic [15:0]       cnt_val
`endif
);

    localparam logic [1:0]      ST_IDLE  = 2'd0;
    localparam logic [1:0]      ST_GRANT = 2'd1;
    localparam logic [1:0]      ST_FLUSH = 2'd2;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] pick;
    logic            found;
    logic [CH_W:0]   rr_sum;
    logic [CH_W-1:0] rr_cand;
    logic            grant_valid;
    logic            grant_last;
    logic            beat;
    logic            start_grant;
    logic            en_q;
    logic            beat_d;
    logic [CH_W-1:0] chan_d;
    logic [7:0]      ch_byte [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_byte[i] = req_data[8*i +: 8];
    end

    assign grant_valid = req_valid[grant_chan];
    assign grant_last  = req_last[grant_chan];
    assign beat        = (state == ST_GRANT) && grant_valid;
    assign start_grant = (state == ST_IDLE) && arb_en && (|req_valid);

    // First valid channel at or above rr_ptr, wrapping modulo N_CH.
    always_comb begin
        pick    = rr_ptr;
        found   = 1'b0;
        rr_sum  = '0;
        rr_cand = '0;
        for (int k = 0; k < N_CH; k++) begin
            rr_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (rr_sum >= (CH_W+1)'(N_CH)) begin
                rr_sum = rr_sum - (CH_W+1)'(N_CH);
            end
            rr_cand = rr_sum[CH_W-1:0];
            if (!found && req_valid[rr_cand]) begin
                pick  = rr_cand;
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_grant) state_next = ST_GRANT;
            ST_GRANT: if (beat && grant_last) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic: the granted stream is steered with zero latency.
    always_comb begin
        req_ready = '0;
        det_data  = 8'h00;
        det_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_GRANT: begin
                req_ready[grant_chan] = 1'b1;
                det_data              = ch_byte[grant_chan];
                det_valid             = grant_valid;
                busy                  = 1'b1;
            end
            ST_FLUSH: begin
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // en_q keeps the detector cleared while reset is asserted and lets it
    // run from the first edge after release; FLUSH clears it between packets.
    assign det_enable = en_q && (state != ST_FLUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q       <= 1'b0;
            grant_chan <= '0;
            rr_ptr     <= '0;
            beat_d     <= 1'b0;
            chan_d     <= '0;
            hit_valid  <= 1'b0;
            hit_chan   <= '0;
        end else begin
            en_q <= 1'b1;
            if (start_grant) begin
                grant_chan <= pick;
            end
            if (state == ST_FLUSH) begin
                rr_ptr <= (grant_chan == LAST_CH) ? '0 : grant_chan + CH_W'(1);
            end
            // The detector output lags the byte by one cycle, so a hit is
            // only accepted when the previous cycle carried a real beat;
            // this gives one pulse even if det_hit stays high over a stall.
            beat_d    <= beat;
            chan_d    <= grant_chan;
            hit_valid <= det_hit && beat_d;
            hit_chan  <= chan_d;
        end
    end

`ifdef SQD_ARB_HITCNT_EN
    logic [15:0] hit_cnt [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_hitcnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hit_cnt[i] <= '0;
            end else if (cnt_clr) begin
                hit_cnt[i] <= '0;
            end else if (hit_valid && (hit_chan == CH_W'(i)) &&
                         (hit_cnt[i] != 16'hFFFF)) begin
                hit_cnt[i] <= hit_cnt[i] + 16'd1;
            end
        end
    end

    assign cnt_val = hit_cnt[cnt_sel];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sqd_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqd_stream_arbiter
// Purpose  : Self-checking bench for sqd_stream_arbiter. A behavioural
//            detector (pattern AA AA FF CF, Moore, cleared by det_enable low)
//            sits behind the block. Directed packets are programmed per
//            channel; expected beats and hits are queued by hand and a
//            negedge monitor pops and compares them.
// Option   : SQD_ARB_HITCNT_EN enables the hit counter checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqd_stream_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;
    localparam int MAXB = 16;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              arb_en    = 1'b0;
    logic [N_CH-1:0]   req_valid = '0;
    logic [8*N_CH-1:0] req_data  = '0;
    logic [N_CH-1:0]   req_last  = '0;
    logic [N_CH-1:0]   req_ready;
    logic [7:0]        det_data;
    logic              det_valid;
    logic              det_enable;
    logic              det_hit   = 1'b0;
    logic              hit_valid;
    logic [CH_W-1:0]   hit_chan;
    logic              busy;
    logic [CH_W-1:0]   grant_chan;
`ifdef SQD_ARB_HITCNT_EN
    logic [CH_W-1:0]   cnt_sel   = '0;
    logic              cnt_clr   = 1'b0;
    logic [15:0]       cnt_val;
`endif

    sqd_stream_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .det_data   (det_data),
        .det_valid  (det_valid),
        .det_enable (det_enable),
        .det_hit    (det_hit),
        .hit_valid  (hit_valid),
        .hit_chan   (hit_chan),
        .busy       (busy),
        .grant_chan (grant_chan)
`ifdef SQD_ARB_HITCNT_EN
        ,
        .cnt_sel    (cnt_sel),
        .cnt_clr    (cnt_clr),
        .cnt_val    (cnt_val)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural detector for AA AA FF CF.
    logic [31:0] hist = '0;
    always @(posedge clk) begin
        if (!det_enable) begin
            hist    <= '0;
            det_hit <= 1'b0;
        end else if (det_valid) begin
            hist    <= {hist[23:0], det_data};
            det_hit <= ({hist[23:0], det_data} == 32'hAAAAFFCF);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard
    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [7:0]      data;
        logic            hit;
    } beat_t;
    typedef struct {
        logic [CH_W-1:0] ch;
        int              at;
    } hit_t;
    beat_t exp_beats[$];
    hit_t  exp_hits[$];

    task automatic expb(input int ch, input logic [7:0] data, input logic hit);
        beat_t b;
        b.ch   = CH_W'(ch);
        b.data = data;
        b.hit  = hit;
        exp_beats.push_back(b);
    endtask

    // Monitor
    int busy_cnt = 0;
    initial begin
        int low_run;
        beat_t b;
        hit_t  h;
        low_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                low_run = 0;
            end else begin
                chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
                if (busy) busy_cnt++;
                if (!det_enable) begin
                    low_run++;
                end else begin
                    if (low_run > 0) chk("flush_len", 64'(low_run), 64'd1);
                    low_run = 0;
                end
                if ((req_valid & req_ready) != '0) begin
                    if (exp_beats.size() == 0) begin
                        chk("beat_unexpected", 64'(req_ready), 64'd0);
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_chan", 64'(grant_chan), 64'(b.ch));
                        chk("beat_ready", 64'(req_ready), 64'(4'b0001 << b.ch));
                        chk("beat_data", 64'(det_data), 64'(b.data));
                        chk("beat_detvalid", 64'(det_valid), 64'd1);
                        if (b.hit) begin
                            h.ch = b.ch;
                            h.at = cyc + 2;
                            exp_hits.push_back(h);
                        end
                    end
                end
                if (hit_valid) begin
                    if (exp_hits.size() == 0) begin
                        chk("hit_unexpected", 64'(hit_valid), 64'd0);
                    end else begin
                        h = exp_hits.pop_front();
                        chk("hit_chan", 64'(hit_chan), 64'(h.ch));
                        chk("hit_cycle", 64'(cyc), 64'(h.at));
                    end
                end
            end
        end
    end

    // Per-channel stimulus program
    logic [7:0] p_data [N_CH][MAXB];
    logic       p_last [N_CH][MAXB];
    int         p_gap  [N_CH][MAXB];
    int         p_len  [N_CH];
    int         fv     [N_CH];
    int         fr     [N_CH];

    task automatic add(input int ch, input logic [7:0] data, input logic last, input int gap);
        p_data[ch][p_len[ch]] = data;
        p_last[ch][p_len[ch]] = last;
        p_gap[ch][p_len[ch]]  = gap;
        p_len[ch]++;
    endtask

    task automatic run(input int budget);
        int idx  [N_CH];
        int gapc [N_CH];
        bit acc  [N_CH];
        bit done;
        done = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            idx[c]  = 0;
            gapc[c] = (p_len[c] > 0) ? p_gap[c][0] : 0;
            fv[c]   = -1;
            fr[c]   = -1;
        end
        for (int n = 0; n < budget; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (idx[c] < p_len[c] && gapc[c] == 0) begin
                    req_valid[c]      = 1'b1;
                    req_data[8*c +: 8] = p_data[c][idx[c]];
                    req_last[c]       = p_last[c][idx[c]];
                    if (fv[c] < 0) fv[c] = cyc;
                end else begin
                    req_valid[c]      = 1'b0;
                    req_data[8*c +: 8] = 8'h00;
                    req_last[c]       = 1'b0;
                end
            end
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                acc[c] = req_valid[c] && req_ready[c];
                if (req_ready[c] && fr[c] < 0) fr[c] = cyc;
            end
            @(posedge clk);
            #1;
            done = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (acc[c]) begin
                    idx[c]++;
                    if (idx[c] < p_len[c]) gapc[c] = p_gap[c][idx[c]];
                end else if (gapc[c] > 0) begin
                    gapc[c]--;
                end
                if (idx[c] < p_len[c]) done = 1'b0;
            end
            if (done) break;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        chk("run_complete", 64'(done), 64'd1);
        for (int c = 0; c < N_CH; c++) p_len[c] = 0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic end_test(input string name);
        chk({name, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
        chk({name, "_hits_left"}, 64'(exp_hits.size()), 64'd0);
        exp_beats.delete();
        exp_hits.delete();
    endtask

    task automatic zero_outs(input string name);
        chk(name, {req_ready, det_valid, det_enable, hit_valid, hit_chan, busy, grant_chan},
            64'd0);
    endtask

    task automatic reset_seq();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        zero_outs("reset_state");
        reset = 1'b0;
        #1;
        chk("det_enable_after_release", 64'(det_enable), 64'd0);
        @(posedge clk);
        #1;
        chk("det_enable_first_edge", 64'(det_enable), 64'd1);
    endtask

    initial begin
        int b0;
        for (int c = 0; c < N_CH; c++) p_len[c] = 0;
        arb_en = 1'b1;
        reset_seq();

        // Test 1: single channel 1 packet, hit on CF
        add(1, 8'hAA, 1'b0, 0); add(1, 8'hAA, 1'b0, 0);
        add(1, 8'hFF, 1'b0, 0); add(1, 8'hCF, 1'b1, 0);
        expb(1, 8'hAA, 1'b0); expb(1, 8'hAA, 1'b0);
        expb(1, 8'hFF, 1'b0); expb(1, 8'hCF, 1'b1);
        b0 = busy_cnt;
        run(40);
        chk("t1_grant_latency", 64'(fr[1] - fv[1]), 64'd1);
        chk("t1_busy_cycles", 64'(busy_cnt - b0), 64'd5);
        chk("t1_idle", 64'(busy), 64'd0);
        end_test("t1");

        // Test 2: channels 0, 2, 3 concurrent from rr_ptr=0
        reset_seq();
        add(0, 8'h11, 1'b0, 0); add(0, 8'h22, 1'b1, 0);
        add(2, 8'h33, 1'b1, 0);
        add(3, 8'h44, 1'b0, 0); add(3, 8'h55, 1'b1, 0);
        expb(0, 8'h11, 1'b0); expb(0, 8'h22, 1'b0);
        expb(2, 8'h33, 1'b0);
        expb(3, 8'h44, 1'b0); expb(3, 8'h55, 1'b0);
        run(60);
        end_test("t2");

        // Test 3: flush prevents a cross-stream match
        add(0, 8'hAA, 1'b0, 0); add(0, 8'hAA, 1'b1, 0);
        add(1, 8'hFF, 1'b0, 0); add(1, 8'hCF, 1'b1, 0);
        expb(0, 8'hAA, 1'b0); expb(0, 8'hAA, 1'b0);
        expb(1, 8'hFF, 1'b0); expb(1, 8'hCF, 1'b0);
        run(60);
        end_test("t3");

        // Test 4: hit followed by a 3-cycle stall gives one pulse
        add(2, 8'hAA, 1'b0, 0); add(2, 8'hAA, 1'b0, 0);
        add(2, 8'hFF, 1'b0, 0); add(2, 8'hCF, 1'b0, 0);
        add(2, 8'h00, 1'b1, 3);
        expb(2, 8'hAA, 1'b0); expb(2, 8'hAA, 1'b0);
        expb(2, 8'hFF, 1'b0); expb(2, 8'hCF, 1'b1);
        expb(2, 8'h00, 1'b0);
        run(60);
        end_test("t4");

        // Test 5: reset mid-packet on channel 3 clears the detector
        add(3, 8'hAA, 1'b0, 0); add(3, 8'hAA, 1'b0, 0);
        expb(3, 8'hAA, 1'b0); expb(3, 8'hAA, 1'b0);
        run(40);
        chk("t5_still_granted", 64'({busy, req_ready}), 64'h18);
        #2;
        reset = 1'b1;
        #1;
        zero_outs("t5_async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        add(3, 8'hFF, 1'b0, 0); add(3, 8'hCF, 1'b1, 0);
        expb(3, 8'hFF, 1'b0); expb(3, 8'hCF, 1'b0);
        run(40);
        end_test("t5");

`ifdef SQD_ARB_HITCNT_EN
        // Counter: three detections on channel 1
        reset_seq();
        for (int p = 0; p < 3; p++) begin
            add(1, 8'hAA, 1'b0, 0); add(1, 8'hAA, 1'b0, 0);
            add(1, 8'hFF, 1'b0, 0); add(1, 8'hCF, 1'b1, 0);
            expb(1, 8'hAA, 1'b0); expb(1, 8'hAA, 1'b0);
            expb(1, 8'hFF, 1'b0); expb(1, 8'hCF, 1'b1);
        end
        run(80);
        cnt_sel = 2'd1;
        #1;
        chk("cnt_three", 64'(cnt_val), 64'd3);
        end_test("tc1");

        // Counter: clear coincident with a hit wins
        add(1, 8'hAA, 1'b0, 0); add(1, 8'hAA, 1'b0, 0);
        add(1, 8'hFF, 1'b0, 0); add(1, 8'hCF, 1'b1, 0);
        expb(1, 8'hAA, 1'b0); expb(1, 8'hAA, 1'b0);
        expb(1, 8'hFF, 1'b0); expb(1, 8'hCF, 1'b1);
        fork
            run(40);
            begin
                for (int n = 0; n < 30; n++) begin
                    @(negedge clk);
                    if (hit_valid) begin
                        cnt_clr = 1'b1;
                        @(posedge clk);
                        #1;
                        cnt_clr = 1'b0;
                        break;
                    end
                end
            end
        join
        #1;
        chk("cnt_clr_priority", 64'(cnt_val), 64'd0);
        end_test("tc2");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sqd_stream_arbiter.md
# sqd_stream_arbiter

Shares one byte-wide sequence detector between N_CH packetised byte streams. It grants one requester per packet in round-robin order and steers that requester's bytes into the detector. Between packets it flushes the detector, so patterns never span two streams. Each detector hit is tagged with the channel whose byte completed it. The block sits directly in front of the detector, which it drives and observes through the `det_*` ports.

## Interface
Parameters:
- N_CH, 4: number of requesting streams (2..8).
- CH_W, 2: channel index width, equal to clog2(N_CH).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- arb_en  in  1  when high, new grants are allowed; a packet already in progress always completes.
- req_valid  in  N_CH  per-channel byte valid.
- req_data  in  8*N_CH  per-channel byte; channel i occupies bits [8i+7:8i].
- req_last  in  N_CH  marks the final byte of a packet; qualified by valid.
- req_ready  out  N_CH  per-channel ready; one-hot or zero.
- det_data  out  8  byte to the detector.
- det_valid  out  1  byte valid to the detector.
- det_enable  out  1  detector enable; low clears the detector.
- det_hit  in  1  the detector's detected output (Moore, 1 cycle after the final byte).
- hit_valid  out  1  one-cycle pulse per qualified detection.
- hit_chan  out  CH_W  channel of the byte that completed the detection; valid with hit_valid.
- busy  out  1  high in GRANT and FLUSH.
- grant_chan  out  CH_W  currently granted channel.

## Operation
- FSM states:
  - IDLE: det_enable=1 and no ready asserted. If arb_en is high and any req_valid is high, pick the first valid channel searching upward from rr_ptr with wrap-around. Register that channel into grant_chan and go to GRANT.
  - GRANT: req_ready[grant_chan]=1 and all other ready bits are 0. det_data = req_data of the granted channel and det_valid = req_valid[grant_chan], both combinational.
    - A beat is valid && ready.
    - A beat with req_last set goes to FLUSH.
    - If req_valid is low, the grant is held and nothing is sent (stall).
  - FLUSH: one cycle with det_enable=0, det_valid=0 and all ready bits 0. rr_ptr becomes (grant_chan+1) mod N_CH. Next state is IDLE.
- Hit qualification:
  - beat_d and chan_d register the beat flag and grant_chan each cycle.
  - hit_valid is registered as det_hit && beat_d; hit_chan is registered from chan_d.
  - det_hit held high across stall cycles therefore produces exactly one pulse.
- A hit caused by the last byte of a packet is sampled during FLUSH and reported normally.
- Concurrent requests are served in order; only the winner sees ready. Losers wait with no timeout.
- If arb_en goes low mid-packet, the packet completes and the block then stays in IDLE.
- Reset: state=IDLE, rr_ptr=0, grant_chan=0, and req_ready, det_valid, det_enable, hit_valid, hit_chan and busy are all 0. det_enable rises on the first clock edge after reset is released.
- Reset during a packet aborts it immediately. The detector is cleared through det_enable=0.

## Timing
- Grant latency: from req_valid sampled in IDLE to req_ready high is 1 cycle.
- Throughput: a packet of L beats without stalls occupies L+2 cycles (IDLE, L beats, FLUSH).
- Datapath latency: zero cycles from req_data to det_data.
- Hit latency: hit_valid pulses 2 cycles after the clock edge that transfers the completing byte (detector registers the byte, then the hit is registered here).
- Two back-to-back packets on the same channel always pass through FLUSH and IDLE between them.

## Configuration
- SQD_ARB_HITCNT_EN, when defined:
  - Adds input cnt_sel (CH_W), input cnt_clr (1) and output cnt_val (16).
  - Each channel has a 16-bit hit counter that increments on hit_valid for hit_chan and saturates at 0xFFFF.
  - cnt_val = counter[cnt_sel], combinational.
  - cnt_clr zeroes all counters synchronously and takes priority over an increment in the same cycle.
  - reset clears all counters.
- When not defined: none of these ports or counters exist, and behaviour is otherwise identical.

## Test plan
- Channel 1 only sends AA,AA,FF,CF with last on CF.
  - req_ready[1] rises 1 cycle after valid.
  - hit_valid pulses once, 2 cycles after the CF beat, with hit_chan=1.
  - The block returns to IDLE after 6 cycles total.
- Channels 0, 2 and 3 hold valid simultaneously with rr_ptr=0.
  - Grants go 0, 2, 3.
  - det_enable is low for exactly one cycle between packets.
  - Ready is never high on two channels in the same cycle.
- Channel 0 sends AA,AA (last); channel 1 then sends FF,CF (last).
  - No hit is reported, proving the flush prevents cross-stream matches.
- Channel 2 sends AA,AA,FF,CF, then stalls 3 cycles with valid low before sending 00 (last).
  - Exactly one hit_valid pulse, with hit_chan=2.
- Reset is asserted mid-packet after AA,AA on channel 3.
  - All outputs go to 0 asynchronously.
  - After release, channel 3 resends FF,CF and no hit is reported.
- With SQD_ARB_HITCNT_EN defined:
  - Three detections on channel 1 followed by cnt_sel=1 give cnt_val=3.
  - cnt_clr asserted in the same cycle as a hit_valid gives cnt_val=0.
